comparator_nbit_pipe: RTL and testbench

Pipelined N-bit magnitude comparator that supersedes the fixed 4-bit dataflow comparator. It compares operands A and B chunk by chunk, MSB chunk first, one chunk per pipeline stage. It uses valid/ready handshakes on both sides and gives a one-hot greater/equal/less result. It sits between operand producers (ALU, sort/search datapaths) and consumers that need registered, backpressure-aware compare results at widths where a flat combinational compare misses timing.

---
 rtl/comparator_nbit_pipe.sv | 119 +++++++++++
 tb/tb_comparator_nbit_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/comparator_nbit_pipe.sv
// Pipelined N-bit magnitude comparator: one CHUNK per stage, MSB chunk first, global-stall flow.
// Define COMPARATOR_SIGNED_EN to honour is_signed (two's-complement compare via MSB inversion).
module comparator_nbit_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned Stages = WIDTH / CHUNK;

  logic                advance;
  logic [Stages-1:0]   valid_q, decided_q, gt_q, lt_q;
  logic [Stages-1:0]   valid_d, decided_d, gt_d, lt_d;
  logic [Stages-1:0]   src_valid, src_decided, src_gt, src_lt;
  logic [WIDTH-1:0]    a_in, b_in;
  // Operand registers hold the not-yet-compared bits left-aligned, next chunk on top.
  logic [WIDTH-1:0]    a_q [Stages];
  logic [WIDTH-1:0]    b_q [Stages];
  logic [WIDTH-1:0]    a_d [Stages];
  logic [WIDTH-1:0]    b_d [Stages];
  logic [WIDTH-1:0]    src_a [Stages];
  logic [WIDTH-1:0]    src_b [Stages];
  logic                unused_tail;

`ifdef COMPARATOR_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_in = a ^ {is_signed, {(WIDTH-1){1'b0}}};
  assign b_in = b ^ {is_signed, {(WIDTH-1){1'b0}}};
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_in = a;
  assign b_in = b;
`endif

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    src_a[0]       = a_in;
    src_b[0]       = b_in;
    src_valid[0]   = in_valid;
    src_decided[0] = 1'b0;
    src_gt[0]      = 1'b0;
    src_lt[0]      = 1'b0;
    for (int unsigned k = 1; k < Stages; k++) begin
      src_a[k]       = a_q[k-1];
      src_b[k]       = b_q[k-1];
      src_valid[k]   = valid_q[k-1];
      src_decided[k] = decided_q[k-1];
      src_gt[k]      = gt_q[k-1];
      src_lt[k]      = lt_q[k-1];
    end
  end

  always_comb begin
    logic [CHUNK-1:0] ca, cb;
    valid_d   = '0;
    decided_d = '0;
    gt_d      = '0;
    lt_d      = '0;
    ca        = '0;
    cb        = '0;
    for (int unsigned k = 0; k < Stages; k++) begin
      ca           = src_a[k][WIDTH-1 -: CHUNK];
      cb           = src_b[k][WIDTH-1 -: CHUNK];
      valid_d[k]   = src_valid[k];
      decided_d[k] = src_decided[k] | (ca != cb);
      gt_d[k]      = src_decided[k] ? src_gt[k] : (ca > cb);
      lt_d[k]      = src_decided[k] ? src_lt[k] : (ca < cb);
      a_d[k]       = src_a[k] << CHUNK;
      b_d[k]       = src_b[k] << CHUNK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      decided_q <= '0;
      gt_q      <= '0;
      lt_q      <= '0;
    end else if (advance) begin
      valid_q   <= valid_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int unsigned k = 0; k < Stages; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
      end
    end
  end

  // The last stage has nothing left to hand on; its operand bits are trimmed away.
  assign unused_tail = ^{a_q[Stages-1], b_q[Stages-1]};

  assign out_valid = valid_q[Stages-1];
  assign gt        = out_valid & gt_q[Stages-1];
  assign lt        = out_valid & lt_q[Stages-1];
  assign eq        = out_valid & ~decided_q[Stages-1];

endmodule

// File: tb/tb_comparator_nbit_pipe.sv
// Randomised and directed bench for comparator_nbit_pipe against a slot-level reference model.
module tb_comparator_nbit_pipe;

  localparam int W = 16;
  localparam int S = 4;
`ifdef COMPARATOR_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         gt, eq, lt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: S slots, each a valid flag plus the expected result (0 lt, 1 eq, 2 gt).
  bit slot_v [S];
  int slot_r [S];

  comparator_nbit_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    bit use_signed;
    use_signed = s & SignedEn;
    if (use_signed) begin
      if ($signed(x) > $signed(y)) return 2;
      if ($signed(x) < $signed(y)) return 0;
      return 1;
    end
    if (x > y) return 2;
    if (x < y) return 0;
    return 1;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < S; k++) begin
      slot_v[k] = 1'b0;
      slot_r[k] = 0;
    end
  endtask

  // One clock: drive at the falling edge, compare 1ns later, advance the model for the next edge.
  task automatic cycle(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb, input bit s,
                       input bit ordy, output bit acc, output bit took);
    bit exp_rdy;
    @(negedge clk);
    in_valid  = v;
    a         = aa;
    b         = bb;
    is_signed = s;
    out_ready = ordy;
    #1;
    exp_rdy = !slot_v[S-1] || ordy;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, slot_v[S-1]);
    check("gt", gt, slot_v[S-1] && slot_r[S-1] == 2);
    check("eq", eq, slot_v[S-1] && slot_r[S-1] == 1);
    check("lt", lt, slot_v[S-1] && slot_r[S-1] == 0);
    took = out_valid && ordy;
    acc  = v && exp_rdy && rst_n;
    if (exp_rdy && rst_n) begin
      for (int k = S - 1; k > 0; k--) begin
        slot_v[k] = slot_v[k-1];
        slot_r[k] = slot_r[k-1];
      end
      slot_v[0] = v;
      slot_r[0] = ref_cmp(aa, bb, s);
    end
  endtask

  task automatic idle(input int n);
    bit acc, took;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
  endtask

  initial begin
    logic [W-1:0] da [6];
    logic [W-1:0] db [6];
    logic [W-1:0] pa, pb;
    bit           ps, pv, acc, took, ordy;
    int           idx, taken, hold_left, n_acc, n_took, cyc;
    bit           first_seen;

    clear_model();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_gt", gt, 1'b0);
    check("rst_eq", eq, 1'b0);
    check("rst_lt", lt, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back gt, eq, lt.
    cycle(1'b1, 16'h1234, 16'h1233, 1'b0, 1'b1, acc, took);
    cycle(1'b1, 16'hABCD, 16'hABCD, 1'b0, 1'b1, acc, took);
    cycle(1'b1, 16'h0FFF, 16'h1000, 1'b0, 1'b1, acc, took);
    // Decided in last stage, then in stage 0.
    cycle(1'b1, 16'h0005, 16'h0004, 1'b0, 1'b1, acc, took);
    cycle(1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, acc, took);
    // Signed pairs in both modes.
    cycle(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, acc, took);
    cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, acc, took);
    cycle(1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, acc, took);
    cycle(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, acc, took);
    idle(S + 2);

    // Mid-stream asynchronous reset with results in flight.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i), 16'(4 - i), 1'b0, 1'b1, acc, took);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_gt", gt, 1'b0);
    check("mid_rst_eq", eq, 1'b0);
    check("mid_rst_lt", lt, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    clear_model();
    cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
    @(negedge clk);
    rst_n = 1'b1;
    idle(S + 4);

    // Backpressure: 6 pairs, out_ready low for 5 cycles after the first result.
    for (int i = 0; i < 6; i++) begin
      da[i] = 16'($urandom);
      db[i] = (i % 3 == 1) ? da[i] : 16'($urandom);
    end
    idx = 0; taken = 0; hold_left = 0; first_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ordy = !(first_seen && hold_left > 0);
      pv   = (idx < 6);
      pa   = pv ? da[idx] : '0;
      pb   = pv ? db[idx] : '0;
      cycle(pv, pa, pb, 1'b0, ordy, acc, took);
      if (acc) idx++;
      if (took) taken++;
      if (!first_seen && took) begin
        first_seen = 1'b1;
        hold_left  = 5;
      end else if (!ordy) begin
        hold_left--;
      end
    end
    check("bp_results", taken, 6);
    check("bp_accepted", idx, 6);

    // Random traffic, producer holds a pair until accepted.
    n_acc = 0; n_took = 0; cyc = 0;
    pv = 1'b0; pa = '0; pb = '0; ps = 1'b0;
    while (n_acc < 10000 && cyc < 40000) begin
      if (!pv && $urandom_range(0, 9) < 7) begin
        pv = 1'b1;
        pa = 16'($urandom);
        ps = 1'($urandom);
        case ($urandom_range(0, 3))
          0:       pb = pa;
          1:       pb = pa ^ (16'h1 << $urandom_range(0, 15));
          default: pb = 16'($urandom);
        endcase
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle(pv, pa, pb, ps, ordy, acc, took);
      if (acc) begin
        n_acc++;
        pv = 1'b0;
      end
      if (took) n_took++;
      cyc++;
    end
    check("rand_budget", n_acc, 10000);
    for (int i = 0; i < S + 2; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, took);
      if (took) n_took++;
    end
    check("rand_drain", n_took, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
